// File: rtl/rename_if.sv
// rename_if: rename request, renamed-op result, retire and flush signals of rename_unit
interface rename_if #(parameter int AW = 3, parameter int TW = 4, parameter int CW = 5);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_src1;
  logic [AW-1:0] in_src2;
  logic [AW-1:0] in_dst;
  logic          out_valid;
  logic [TW-1:0] out_psrc1;
  logic [TW-1:0] out_psrc2;
  logic [TW-1:0] out_pdst;
  logic [TW-1:0] out_old_pdst;
  logic          retire_ena;
  logic [AW-1:0] retire_arch;
  logic [TW-1:0] retire_pdst;
  logic [TW-1:0] retire_old_pdst;
  logic          flush;
  logic [CW-1:0] free_count;
  modport master (
    output in_valid, in_src1, in_src2, in_dst, retire_ena, retire_arch, retire_pdst, retire_old_pdst, flush,
    input  in_ready, out_valid, out_psrc1, out_psrc2, out_pdst, out_old_pdst, free_count
  );
  modport slave (
    input  in_valid, in_src1, in_src2, in_dst, retire_ena, retire_arch, retire_pdst, retire_old_pdst, flush,
    output in_ready, out_valid, out_psrc1, out_psrc2, out_pdst, out_old_pdst, free_count
  );
endinterface

// File: rtl/rename_unit.sv
// rename_unit: register renaming with speculative/committed map tables and a free-tag vector
module rename_unit #(
  parameter int ARCH_REGS = 8,
  parameter int PRF_SIZE  = 16
) (
  input logic     clk,
  input logic     rst,
  rename_if.slave io
);
  localparam int TW = $clog2(PRF_SIZE);
  localparam int CW = $clog2(PRF_SIZE + 1);
  logic [TW-1:0]       spec_rat  [ARCH_REGS];
  logic [TW-1:0]       arch_rat  [ARCH_REGS];
  logic [TW-1:0]       arch_next [ARCH_REGS];
  logic [PRF_SIZE-1:0] free_q;
  logic [PRF_SIZE-1:0] free_next;
  logic [PRF_SIZE-1:0] used;
  logic [TW-1:0]       alloc;
  logic [CW-1:0]       cnt;
  logic                accept;
  logic                alloc_en;
  assign io.in_ready = !rst && !io.flush && (io.in_dst == '0 || |free_q);
  assign accept      = io.in_valid && io.in_ready;
  assign alloc_en    = accept && io.in_dst != '0;
  always_comb begin
    alloc = '0;
    for (int i = PRF_SIZE - 1; i > 0; i--)
      if (free_q[i]) alloc = TW'(i);
  end
  // flush recovery rebuilds the free vector from the post-retire committed map
  always_comb begin
    arch_next = arch_rat;
    if (io.retire_ena && io.retire_arch != '0) arch_next[io.retire_arch] = io.retire_pdst;
    used = '0;
    for (int i = 0; i < ARCH_REGS; i++) used[arch_next[i]] = 1'b1;
    free_next = free_q;
    if (alloc_en) free_next[alloc] = 1'b0;
    if (io.retire_ena) free_next[io.retire_old_pdst] = 1'b1;
    if (io.flush) free_next = ~used;
    free_next[0] = 1'b0;
    cnt = '0;
    for (int i = 0; i < PRF_SIZE; i++) cnt = cnt + CW'(free_next[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat[i] <= TW'(i);
        arch_rat[i] <= TW'(i);
      end
      for (int i = 0; i < PRF_SIZE; i++) free_q[i] <= i >= ARCH_REGS;
      io.free_count   <= CW'(PRF_SIZE - ARCH_REGS);
      io.out_valid    <= 1'b0;
      io.out_psrc1    <= '0;
      io.out_psrc2    <= '0;
      io.out_pdst     <= '0;
      io.out_old_pdst <= '0;
    end else begin
      arch_rat <= arch_next;
      if (io.flush) spec_rat <= arch_next;
      else if (alloc_en) spec_rat[io.in_dst] <= alloc;
      free_q          <= free_next;
      io.free_count   <= cnt;
      io.out_valid    <= accept;
      io.out_psrc1    <= accept ? spec_rat[io.in_src1] : '0;
      io.out_psrc2    <= accept ? spec_rat[io.in_src2] : '0;
      io.out_pdst     <= alloc_en ? alloc : '0;
      io.out_old_pdst <= alloc_en ? spec_rat[io.in_dst] : '0;
    end
  end
endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: directed rename/retire/flush/reset sequences with hand-computed expectations
module tb_rename_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  rename_if ifc ();
  rename_unit dut (.clk(clk), .rst(rst), .io(ifc));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic v, input int s1, input int s2, input int d);
    ifc.in_valid = v;
    ifc.in_src1  = 3'(s1);
    ifc.in_src2  = 3'(s2);
    ifc.in_dst   = 3'(d);
  endtask
  task automatic set_ret(input logic e, input int a, input int p, input int o);
    ifc.retire_ena      = e;
    ifc.retire_arch     = 3'(a);
    ifc.retire_pdst     = 4'(p);
    ifc.retire_old_pdst = 4'(o);
  endtask
  task automatic check_out(input string tag, input int v, input int p1, input int p2, input int pd, input int old);
    check({tag, ".valid"}, int'(ifc.out_valid), v);
    check({tag, ".psrc1"}, int'(ifc.out_psrc1), p1);
    check({tag, ".psrc2"}, int'(ifc.out_psrc2), p2);
    check({tag, ".pdst"}, int'(ifc.out_pdst), pd);
    check({tag, ".old"}, int'(ifc.out_old_pdst), old);
  endtask
  task automatic do_reset();
    set_in(0, 0, 0, 0);
    set_ret(0, 0, 0, 0);
    ifc.flush = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask
  initial begin
    set_in(0, 0, 0, 0);
    set_ret(0, 0, 0, 0);
    ifc.flush = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    ifc.in_dst = 3'd1;
    #1;
    check_out("reset", 0, 0, 0, 0, 0);
    check("reset.free", int'(ifc.free_count), 8);
    check("reset.ready", int'(ifc.in_ready), 1);
    set_in(1, 2, 3, 1);
    cyc();
    check_out("r1_r2r3", 1, 2, 3, 8, 1);
    check("r1_r2r3.free", int'(ifc.free_count), 7);
    set_in(0, 2, 3, 1);
    cyc();
    check_out("idle", 0, 0, 0, 0, 0);
    do_reset();
    set_in(1, 1, 1, 1);
    cyc();
    check_out("self1", 1, 1, 1, 8, 1);
    cyc();
    check_out("self2", 1, 8, 8, 9, 8);
    check("self2.free", int'(ifc.free_count), 6);
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      set_in(1, 0, 0, (i == 8) ? 1 : i);
      cyc();
      check("exh.pdst", int'(ifc.out_pdst), 7 + i);
    end
    check("exh.old", int'(ifc.out_old_pdst), 8);
    check("exh.free", int'(ifc.free_count), 0);
    set_in(0, 0, 0, 1);
    #1;
    check("exh.ready_r1", int'(ifc.in_ready), 0);
    set_in(1, 2, 3, 0);
    #1;
    check("exh.ready_r0", int'(ifc.in_ready), 1);
    cyc();
    check_out("exh.r0", 1, 9, 10, 0, 0);
    set_in(1, 0, 0, 1);
    set_ret(1, 1, 8, 1);
    #1;
    check("ret.same_cycle_ready", int'(ifc.in_ready), 0);
    cyc();
    set_ret(0, 0, 0, 0);
    check("ret.no_accept", int'(ifc.out_valid), 0);
    check("ret.free", int'(ifc.free_count), 1);
    check("ret.next_ready", int'(ifc.in_ready), 1);
    cyc();
    check_out("ret.alloc", 1, 0, 0, 1, 15);
    check("ret.alloc_free", int'(ifc.free_count), 0);
    do_reset();
    set_in(1, 0, 0, 1);
    cyc();
    set_in(1, 0, 0, 2);
    cyc();
    check("fl.pdst9", int'(ifc.out_pdst), 9);
    set_in(0, 0, 0, 0);
    set_ret(1, 1, 8, 1);
    cyc();
    set_ret(0, 0, 0, 0);
    set_in(1, 0, 0, 5);
    ifc.flush = 1'b1;
    #1;
    check("fl.ready", int'(ifc.in_ready), 0);
    cyc();
    ifc.flush = 1'b0;
    check("fl.valid", int'(ifc.out_valid), 0);
    check("fl.free", int'(ifc.free_count), 8);
    set_in(1, 1, 2, 3);
    cyc();
    check_out("fl.r3", 1, 8, 2, 1, 3);
    set_in(1, 0, 0, 4);
    cyc();
    check("fl.next_free_tag", int'(ifc.out_pdst), 9);
    check("fl.free6", int'(ifc.free_count), 6);
    do_reset();
    set_in(1, 0, 0, 1);
    cyc();
    set_in(0, 0, 0, 0);
    set_ret(1, 1, 8, 1);
    ifc.flush = 1'b1;
    cyc();
    set_ret(0, 0, 0, 0);
    ifc.flush = 1'b0;
    check("flret.valid", int'(ifc.out_valid), 0);
    check("flret.free", int'(ifc.free_count), 8);
    set_in(1, 1, 0, 2);
    cyc();
    check_out("flret.r2", 1, 8, 0, 1, 2);
    set_in(1, 3, 4, 1);
    cyc();
    check("mid.valid", int'(ifc.out_valid), 1);
    rst = 1'b1;
    set_in(1, 0, 0, 0);
    #1;
    check("mid.ready_in_rst", int'(ifc.in_ready), 0);
    cyc();
    rst = 1'b0;
    check_out("mid.rst", 0, 0, 0, 0, 0);
    check("mid.free", int'(ifc.free_count), 8);
    set_in(1, 1, 2, 5);
    cyc();
    check_out("mid.after", 1, 1, 2, 8, 5);
    set_in(0, 0, 0, 0);
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rename_unit.md
RENAME_UNIT -- requirements
Module: rename_unit

Interface
REQ-001 Parameter ARCH_REGS, default 8, number of architectural registers; r0 is hardwired zero.
REQ-002 Parameter PRF_SIZE, default 16, number of physical registers; tag 4 bits; p0 is hardwired zero.
REQ-003 Clock clk and reset rst: reset rst, synchronous, active-high; clock clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  rename request present.
REQ-007 in_ready  out  1  request accepted this cycle.
REQ-008 in_src1, in_src2, in_dst  in  3 each  architectural source and destination indices.
REQ-009 out_valid  out  1  renamed op valid; registered.
REQ-010 out_psrc1, out_psrc2, out_pdst, out_old_pdst  out  4 each  physical tags; out_old_pdst is the previous mapping of in_dst (the PRF's later old_wb).
REQ-011 retire_ena  in  1  oldest op commits.
REQ-012 retire_arch  in  3  committing op's destination arch register.
REQ-013 retire_pdst, retire_old_pdst  in  4 each  committing op's new and previous physical tags.
REQ-014 flush  in  1  discard all speculative renames.
REQ-015 free_count  out  5  number of free physical registers; registered.

Function
REQ-016 State: speculative map table (spec_rat), committed map table (arch_rat), ARCH_REGS x 4 bits each, and a PRF_SIZE-bit free vector; output registers.
REQ-017 in_ready = !flush && (in_dst == 0 || free vector has at least one set bit); in_ready does not depend on in_valid.
REQ-018 Accept = in_valid && in_ready; on accept, psrc1 = spec_rat[in_src1] and psrc2 = spec_rat[in_src2], read before this cycle's update, so a source equal to in_dst gets the old mapping.
REQ-019 On accept with in_dst != 0: pdst = lowest-index set bit of the free vector; that bit is cleared; spec_rat[in_dst] <= pdst; old_pdst = previous spec_rat[in_dst].
REQ-020 On accept with in_dst == 0: pdst = 0 and old_pdst = 0; no allocation; no table change.
REQ-021 Latency 1: the values from REQ-018..020 appear on out_* with out_valid = 1 in the cycle after accept; out_valid = 0 and all out_* = 0 in any cycle following a non-accept.
REQ-022 Retire: when retire_ena = 1, arch_rat[retire_arch] <= retire_pdst, and free bit retire_old_pdst is set unless retire_old_pdst == 0; retire_arch == 0 leaves arch_rat unchanged.
REQ-023 A tag freed by retire becomes allocatable the next cycle, never in the same cycle.
REQ-024 Flush: spec_rat <= arch_rat including any same-cycle retire update; free vector <= set of tags 1..PRF_SIZE-1 not referenced by that arch_rat; out_valid <= 0; no accept that cycle.
REQ-025 Retire and rename in the same cycle both take effect.
REQ-026 Entry 0 of both tables always reads 0; free bit 0 always reads 0.
REQ-027 free_count equals the popcount of the free vector after each cycle's updates.
REQ-028 Free-vector exhaustion: in_ready = 0 for any in_dst != 0; requests with in_dst == 0 are still accepted.
REQ-029 A retire that frees a tag that is already free is illegal input; behaviour is not required.

Reset
REQ-030 On rst: spec_rat[i] and arch_rat[i] <= i for i < ARCH_REGS; free vector <= tags ARCH_REGS..PRF_SIZE-1 (free_count = 8); out_valid and all out_* <= 0.
REQ-031 rst has priority over flush, rename and retire in the same cycle; in_ready is 0 while rst is asserted.

Verification
REQ-032 After reset, rename r1<-r2,r3 -> next cycle: out_psrc1=2, out_psrc2=3, out_pdst=8, out_old_pdst=1, free_count=7.
REQ-033 Rename r1<-r1,r1 twice in consecutive cycles -> outputs: first psrc=1, pdst=8, old=1; second psrc=8, pdst=9, old=8.
REQ-034 Eight renames to r1..r7 exhausting tags 8..15 -> in_ready=0 for dst r1 and 1 for dst r0; retire with old_pdst=1 in cycle N -> in_ready=1 in cycle N+1; next allocation is tag 1.
REQ-035 Rename r1->p8 then r2->p9, retire r1 (pdst 8, old 1), then flush -> spec_rat r1=8, r2=2; free vector = {1,9..15}; free_count=8.
REQ-036 Flush and retire in the same cycle -> recovered spec_rat includes that retire's mapping; no out_valid the following cycle.
REQ-037 rst asserted mid-stream with out_valid=1 -> next cycle: out_valid=0, identity tables, free_count=8.
